key_enc8_3: RTL and testbench
=============================

KEY_ENC8_3 -- requirements
Module: key_enc8_3

Interface
REQ-001 Parameter DEB_MAX, default 1000000, SHALL set the number of consecutive stable clocks needed to accept a press or release (20 ms at 50 MHz).
REQ-002 Parameter CNT_W, default 20, SHALL set the debounce counter width; DEB_MAX SHALL be at most 2^CNT_W.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 key  input  8  SHALL carry active-low, asynchronous push-key levels (0 = pressed).
REQ-006 code  output  3  SHALL carry the encoded index of the accepted key.
REQ-007 valid  output  1  SHALL be high while an accepted key is held (HELD or REL_DEB).
REQ-008 press  output  1  SHALL be a one-cycle strobe on each newly accepted press.
REQ-009 led  output  8  SHALL carry an active-low one-hot echo of code (round-trip check of the 3-8 decoder).

Function
REQ-010 key SHALL pass through a 2-flop synchronizer (reset value 8'hFF) before any other use.
REQ-011 Mapping SHALL be key[7]->3'b000, key[6]->3'b001, ..., key[0]->3'b111 (code = 7 - bit index).
REQ-012 With several keys low, the highest bit index SHALL win (key[7] highest priority).
REQ-013 The debounce counter SHALL clear whenever the synchronized vector differs from its previous-cycle value, and otherwise increment, saturating at DEB_MAX-1.
REQ-014 States SHALL be IDLE, PRESS_DEB, HELD, REL_DEB.
REQ-015 IDLE: a synchronized vector other than 8'hFF SHALL move to PRESS_DEB with the counter cleared.
REQ-016 PRESS_DEB: a return to 8'hFF SHALL go to IDLE; the counter reaching DEB_MAX-1 with the vector unchanged SHALL go to HELD, latch the priority code, and pulse press for exactly one cycle.
REQ-017 HELD: code SHALL stay frozen despite other keys changing; the vector becoming 8'hFF SHALL go to REL_DEB.
REQ-018 REL_DEB: any key low SHALL return to HELD with no press pulse and no code change; 8'hFF stable for DEB_MAX cycles SHALL go to IDLE and drop valid.
REQ-019 Latency: press SHALL assert on rising edge DEB_MAX+3 after a clean key edge that meets setup; valid SHALL rise on the same edge.
REQ-020 led SHALL equal 8'hFF when valid is low; otherwise bit (7-code) SHALL be 0 and all other bits 1.
REQ-021 All outputs SHALL be registered; no combinational path from key to any output.
REQ-022 Bounces shorter than DEB_MAX cycles SHALL never produce press or change code.

Reset
REQ-023 While rst_n is low: state IDLE, counter 0, synchronizer 8'hFF, code 3'b000, valid 0, press 0, led 8'hFF.
REQ-024 Reset mid-operation (any state) SHALL take effect immediately and without glitch; after release, keys still held SHALL be re-debounced from IDLE and produce a new press.

Structure
REQ-025 Package key_enc_pkg SHALL hold the state type, the DEB_MAX and CNT_W defaults, and the active-low all-released constant 8'hFF.
REQ-026 The synchronizer and stable counter SHALL form one sub-module, key_debounce, outputting the synchronized vector and a stable flag; the FSM, priority encoder and led echo SHALL be in key_enc8_3.

Verification (DEB_MAX=4)
REQ-027 key=8'hFF -> 8'hBF held 20 cycles -> exactly one press, code=3'b001, led=8'hBF, valid=1 from edge 7.
REQ-028 key toggles 8'hFF/8'hEF every 2 cycles for 30 cycles, then 8'hFF -> press never asserts; valid stays 0.
REQ-029 key=8'h7E (keys 7 and 0) -> code=3'b000, led=8'h7F; then key=8'hFE -> code holds 3'b000, no new press.
REQ-030 Hold 8'hFE, release for 2 cycles, press again -> valid stays 1, single press total; release for 10 cycles -> valid=0, led=8'hFF.
REQ-031 Assert rst_n low while in HELD with 8'hF7 held, release reset -> all outputs at reset values immediately; press re-fires with code=3'b100 after DEB_MAX+3 edges.

Source files
------------

// File: rtl/key_enc_pkg.sv
// Shared types and constants for the debounced 8-to-3 push-key encoder.
// Pure declarations: no state, no latency, no flow control.
package key_enc_pkg;

  localparam int DEB_MAX_DEF = 1000000;
  localparam int CNT_W_DEF   = 20;

  // Active-low keys: all ones means nothing is pressed.
  localparam logic [7:0] KEYS_REL = 8'hFF;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE      = 2'd0;
  localparam state_t ST_PRESS_DEB = 2'd1;
  localparam state_t ST_HELD      = 2'd2;
  localparam state_t ST_REL_DEB   = 2'd3;

  // Highest low bit wins; key[7] encodes to 0, key[0] to 7.
  function automatic logic [2:0] pri_code(input logic [7:0] keys);
    logic [2:0] c;
    c = 3'b000;
    for (int i = 0; i < 8; i++) begin
      if (!keys[i]) c = 3'(7 - i);
    end
    return c;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop key synchronizer plus stable-run counter; sync is 2 cycles behind key.
// stable rises once the synced vector has held for DEB_MAX-1 counts; no backpressure.
module key_debounce
  import key_enc_pkg::*;
#(
  parameter int DEB_MAX = DEB_MAX_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key,
  input  logic       clr,
  output logic [7:0] sync,
  output logic       stable
);

  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(DEB_MAX - 1);

  logic [7:0]       meta_q, meta_d;
  logic [7:0]       sync_q, sync_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    meta_d = key;
    sync_d = meta_q;
    cnt_d  = cnt_q;
    // meta_q != sync_q means the synced vector changes on this edge.
    if (clr || (meta_q != sync_q)) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_TOP) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= KEYS_REL;
      sync_q <= KEYS_REL;
      cnt_q  <= '0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
    end
  end

  assign sync   = sync_q;
  assign stable = (cnt_q == CNT_TOP);

endmodule

// File: rtl/key_enc8_3.sv
// Debounced priority encoder for 8 active-low keys with one-cycle press strobe and led echo.
// press/valid rise DEB_MAX+3 edges after a clean key edge; all outputs registered, no backpressure.
module key_enc8_3
  import key_enc_pkg::*;
#(
  parameter int DEB_MAX = DEB_MAX_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] key,
  output logic [2:0] code,
  output logic       valid,
  output logic       press,
  output logic [7:0] led
);

  logic [7:0] sync;
  logic       stable;
  logic       clr;

  state_t     state_q, state_d;
  logic [2:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       press_q, press_d;
  logic [7:0] led_q, led_d;

  key_debounce #(
    .DEB_MAX (DEB_MAX),
    .CNT_W   (CNT_W)
  ) u_deb (
    .clk    (clk),
    .rst_n  (rst_n),
    .key    (key),
    .clr    (clr),
    .sync   (sync),
    .stable (stable)
  );

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    press_d = 1'b0;
    clr     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sync != KEYS_REL) begin
          state_d = ST_PRESS_DEB;
          clr     = 1'b1;
        end
      end
      ST_PRESS_DEB: begin
        if (sync == KEYS_REL) begin
          state_d = ST_IDLE;
        end else if (stable) begin
          state_d = ST_HELD;
          code_d  = pri_code(sync);
          press_d = 1'b1;
        end
      end
      ST_HELD: begin
        if (sync == KEYS_REL) begin
          state_d = ST_REL_DEB;
          clr     = 1'b1;
        end
      end
      default: begin
        // A key coming back during release debounce resumes the hold silently.
        if (sync != KEYS_REL) begin
          state_d = ST_HELD;
        end else if (stable) begin
          state_d = ST_IDLE;
        end
      end
    endcase
    valid_d = (state_d == ST_HELD) || (state_d == ST_REL_DEB);
    led_d   = valid_d ? ~(8'h80 >> code_d) : KEYS_REL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      code_q  <= 3'b000;
      valid_q <= 1'b0;
      press_q <= 1'b0;
      led_q   <= KEYS_REL;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      press_q <= press_d;
      led_q   <= led_d;
    end
  end

  assign code  = code_q;
  assign valid = valid_q;
  assign press = press_q;
  assign led   = led_q;

endmodule

// File: tb/tb_key_enc8_3.sv
// Directed and random stimulus for key_enc8_3 (DEB_MAX=4) against an elapsed-time reference model.
module tb_key_enc8_3;

  localparam int DEB = 4;
  localparam int CW  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] key = 8'hFF;
  logic [2:0] code;
  logic       valid;
  logic       press;
  logic [7:0] led;

  key_enc8_3 #(.DEB_MAX(DEB), .CNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .key   (key),
    .code  (code),
    .valid (valid),
    .press (press),
    .led   (led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int presses = 0;

  // Reference model: phase plus the edge numbers of the last phase entry and last synced-vector change.
  int         n = 0;
  int         m_phase = 0;  // 0 idle, 1 press debounce, 2 held, 3 release debounce
  int         last_chg = 0;
  int         entry = 0;
  logic [7:0] p1 = 8'hFF;   // key seen one edge ago
  logic [7:0] p2 = 8'hFF;   // key seen two edges ago = synced vector now
  logic [2:0] e_code = 3'd0;
  logic       e_valid = 1'b0;
  logic       e_press = 1'b0;

  function automatic logic [2:0] ref_code(input logic [7:0] kv);
    for (int i = 7; i >= 0; i--) begin
      if (!kv[i]) return 3'(7 - i);
    end
    return 3'd0;
  endfunction

  function automatic logic [7:0] ref_led(input logic v, input logic [2:0] c);
    logic [7:0] l;
    for (int i = 0; i < 8; i++) l[i] = !(v && (i == 7 - int'(c)));
    return l;
  endfunction

  task automatic model_step(input logic [7:0] kn, input logic rst_now);
    int  since;
    logic [7:0] sp;
    n++;
    if (!rst_now) begin
      m_phase = 0; e_code = 3'd0; e_valid = 1'b0; e_press = 1'b0;
      p1 = 8'hFF; p2 = 8'hFF; last_chg = n; entry = n;
      return;
    end
    sp = p2;
    since = (n - 1) - ((last_chg > entry) ? last_chg : entry);
    e_press = 1'b0;
    case (m_phase)
      0: if (sp != 8'hFF) begin m_phase = 1; entry = n; end
      1: begin
        if (sp == 8'hFF) m_phase = 0;
        else if (since >= DEB - 1) begin m_phase = 2; e_code = ref_code(sp); e_press = 1'b1; end
      end
      2: if (sp == 8'hFF) begin m_phase = 3; entry = n; end
      default: begin
        if (sp != 8'hFF) m_phase = 2;
        else if (since >= DEB - 1) m_phase = 0;
      end
    endcase
    if (p1 != p2) last_chg = n;
    p2 = p1;
    p1 = kn;
    e_valid = (m_phase == 2) || (m_phase == 3);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [7:0] kv);
    key = kv;
    @(posedge clk);
    model_step(kv, rst_n);
    #1;
    if (press === 1'b1) presses++;
    chk("code",  32'(code),  32'(e_code));
    chk("valid", 32'(valid), 32'(e_valid));
    chk("press", 32'(press), 32'(e_press));
    chk("led",   32'(led),   32'(ref_led(e_valid, e_code)));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_code"},  32'(code),  32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_press"}, 32'(press), 32'd0);
    chk({tag, "_led"},   32'(led),   32'hFF);
  endtask

  initial begin
    int first;
    int base;
    logic vseen;
    logic vlow;
    logic [7:0] kv;

    // Reset state
    step(8'hFF);
    step(8'hFF);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // Single clean press of key[6]
    first = 0; base = presses;
    for (int i = 1; i <= 20; i++) begin
      step(8'hBF);
      if (press === 1'b1 && first == 0) first = i;
    end
    chk("t1_press_edge", 32'(first), 32'(DEB + 3));
    chk("t1_press_cnt", 32'(presses - base), 32'd1);
    chk("t1_code", 32'(code), 32'd1);
    chk("t1_led", 32'(led), 32'hBF);
    chk("t1_valid", 32'(valid), 32'd1);
    repeat (12) step(8'hFF);
    chk("t1_rel_valid", 32'(valid), 32'd0);

    // Bouncing key[4] never accepted
    base = presses; vseen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step(((i >> 1) & 1) != 0 ? 8'hFF : 8'hEF);
      vseen |= valid;
    end
    repeat (8) begin step(8'hFF); vseen |= valid; end
    chk("t2_press_cnt", 32'(presses - base), 32'd0);
    chk("t2_valid_seen", 32'(vseen), 32'd0);

    // Priority, then code freeze while held
    repeat (10) step(8'h7E);
    chk("t3_code", 32'(code), 32'd0);
    chk("t3_led", 32'(led), 32'h7F);
    base = presses;
    repeat (10) step(8'hFE);
    chk("t3_code_frozen", 32'(code), 32'd0);
    chk("t3_no_new_press", 32'(presses - base), 32'd0);
    repeat (12) step(8'hFF);

    // Short release glitch keeps the hold; long release drops it
    base = presses;
    repeat (10) step(8'hFE);
    vlow = 1'b0;
    repeat (2) begin step(8'hFF); vlow |= !valid; end
    repeat (10) begin step(8'hFE); vlow |= !valid; end
    chk("t4_valid_kept", 32'(vlow), 32'd0);
    chk("t4_press_cnt", 32'(presses - base), 32'd1);
    repeat (10) step(8'hFF);
    chk("t4_valid_drop", 32'(valid), 32'd0);
    chk("t4_led_off", 32'(led), 32'hFF);

    // Reset while held, then re-debounce of the still-held key[3]
    repeat (10) step(8'hF7);
    chk("t5_held_code", 32'(code), 32'd4);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t5_async");
    repeat (2) step(8'hF7);
    rst_n = 1'b1;
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      step(8'hF7);
      if (press === 1'b1 && first == 0) first = i;
    end
    chk("t5_press_edge", 32'(first), 32'(DEB + 3));
    chk("t5_code", 32'(code), 32'd4);

    // Random key patterns with occasional reset pulses
    kv = 8'hFF;
    for (int s = 0; s < 80; s++) begin
      case ($urandom_range(0, 3))
        0: kv = 8'hFF;
        1: kv = ~(8'h01 << $urandom_range(0, 7));
        2: kv = 8'($urandom);
        default: kv = kv;
      endcase
      if ($urandom_range(0, 19) == 0) begin
        rst_n = 1'b0;
        step(kv);
        rst_n = 1'b1;
      end
      repeat ($urandom_range(1, 9)) step(kv);
    end
    repeat (12) step(8'hFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
